// File: rtl/dmb_tail_pkg.sv
// Shared types and constants for the DMB event trailer generator.
// Holds the trailer FSM state type, word markers and the 16-bit-per-step CRC-22 function.
package dmb_tail_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LATCH,
    SEND,
    DONE
  } tail_state_e;

  localparam logic [3:0]  TAIL_MK_F  = 4'hF;
  localparam logic [3:0]  TAIL_MK_E  = 4'hE;
  localparam logic [21:0] CRC22_POLY = 22'h000003;
  localparam int unsigned NTAIL      = 8;

  // Sixteen serial MSB-first shifts of x^22+x+1 collapsed into one step.
  function automatic logic [21:0] crc22_w16(input logic [21:0] crc, input logic [15:0] d);
    logic [21:0] c;
    logic        fb;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      fb = c[21] ^ d[i];
      c  = {c[20:0], 1'b0} ^ ({22{fb}} & CRC22_POLY);
    end
    return c;
  endfunction

endpackage

// File: rtl/dmb_crc22_w16.sv
// Combinational next-CRC for one 16-bit word.
module dmb_crc22_w16
  import dmb_tail_pkg::*;
(
  input  logic [21:0] crc,
  input  logic [15:0] d,
  output logic [21:0] crc_nxt
);

  assign crc_nxt = crc22_w16(crc, d);

endmodule

// File: rtl/dmb_tail_gen.sv
// Event trailer generator: counts and CRCs event words, then emits an eight-word trailer
// (L1A, error flags, word count, CRC-22) over a valid/ready stream.
module dmb_tail_gen
  import dmb_tail_pkg::*;
#(
  parameter int unsigned WC_W = 22
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR_EVT,
  input  logic        DIN_VLD,
  input  logic [15:0] DIN,
  input  logic        STRT_TAIL,
  input  logic [23:0] L1A_NUM,
  input  logic [7:0]  ERR_FLAGS,
  input  logic        DOUT_RDY,
  output logic [15:0] DOUT,
  output logic        DOUT_VLD,
  output logic        DOUT_LAST,
  output logic        TAIL_BUSY,
  output logic        TAIL_DONE,
  output logic        WC_OVF
);

  localparam logic [WC_W-1:0] WC_MAX = '1;

  tail_state_e      state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [WC_W-1:0]  wc_t_q, wc_t_d;
  logic [21:0]      crc_q, crc_d;
  logic             ovf_q, ovf_d;
  logic             late_q, late_d;
  logic [2:0]       idx_q, idx_d;
  logic [23:0]      l1a_q, l1a_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;

  logic [21:0]      crc_in, crc_nxt;
  logic [15:0]      crc_data;
  logic [WC_W:0]    wc_sum;
  logic [WC_W-1:0]  wc_t_sat;
  logic [WC_W-1:0]  wbase;
  logic [2:0]       idx_nxt;
  logic [7:0]       err_eff;
  logic             xfer;

  function automatic logic [15:0] tail_word(input logic [2:0]  i,
                                            input logic [23:0] l1a,
                                            input logic [7:0]  err,
                                            input logic        ovf,
                                            input logic [21:0] wct,
                                            input logic [21:0] crc);
    logic [15:0] w;
    case (i)
      3'd0:    w = {TAIL_MK_F, l1a[11:0]};
      3'd1:    w = {TAIL_MK_F, l1a[23:12]};
      3'd2:    w = {TAIL_MK_F, 4'h0, err};
      3'd3:    w = {TAIL_MK_F, 3'b000, ovf, 8'h00};
      3'd4:    w = {TAIL_MK_E, wct[11:0]};
      3'd5:    w = {TAIL_MK_E, 2'b00, wct[21:12]};
      3'd6:    w = {TAIL_MK_E, 1'b0, crc[10:0]};
      default: w = {TAIL_MK_E, 1'b0, crc[21:11]};
    endcase
    return w;
  endfunction

  // One CRC engine serves both event data (IDLE) and the outgoing trailer words (SEND).
  assign crc_in   = (state_q == IDLE && CLR_EVT) ? '0 : crc_q;
  assign crc_data = (state_q == IDLE) ? DIN : dout_q;

  dmb_crc22_w16 u_crc (
    .crc     (crc_in),
    .d       (crc_data),
    .crc_nxt (crc_nxt)
  );

  assign wc_sum   = {1'b0, wcnt_q} + (WC_W + 1)'(NTAIL);
  assign wc_t_sat = wc_sum[WC_W] ? WC_MAX : wc_sum[WC_W-1:0];
  assign wbase    = CLR_EVT ? '0 : wcnt_q;
  assign idx_nxt  = idx_q + 3'd1;
  assign xfer     = vld_q & DOUT_RDY;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wc_t_d  = wc_t_q;
    crc_d   = crc_q;
    ovf_d   = ovf_q;
    late_d  = late_q;
    idx_d   = idx_q;
    l1a_d   = l1a_q;
    err_d   = err_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    last_d  = last_q;

    // Words arriving once the trailer has started are dropped and flagged in W2.
    if (state_q != IDLE && DIN_VLD) begin
      late_d = 1'b1;
    end
    err_eff = {err_q[7] | late_d, err_q[6:0]};

    unique case (state_q)
      IDLE: begin
        wcnt_d = wbase;
        if (CLR_EVT) begin
          crc_d = '0;
          ovf_d = 1'b0;
        end
        if (DIN_VLD) begin
          crc_d = crc_nxt;
          if (wbase == WC_MAX) begin
            ovf_d = 1'b1;
          end else begin
            wcnt_d = wbase + 1'b1;
          end
        end
        if (STRT_TAIL) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        l1a_d   = L1A_NUM;
        err_d   = ERR_FLAGS;
        wc_t_d  = wc_t_sat;
        idx_d   = 3'd0;
        dout_d  = tail_word(3'd0, L1A_NUM, ERR_FLAGS, ovf_q, 22'(wc_t_sat), crc_q);
        vld_d   = 1'b1;
        last_d  = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (idx_q <= 3'd5) begin
            crc_d = crc_nxt;
          end
          if (idx_q == 3'd7) begin
            dout_d  = '0;
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d  = idx_nxt;
            dout_d = tail_word(idx_nxt, l1a_q, err_eff, ovf_q, 22'(wc_t_q), crc_d);
            last_d = (idx_nxt == 3'd7);
          end
        end
      end
      DONE: begin
        wcnt_d  = '0;
        crc_d   = '0;
        ovf_d   = 1'b0;
        late_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      wc_t_q  <= '0;
      crc_q   <= '0;
      ovf_q   <= 1'b0;
      late_q  <= 1'b0;
      idx_q   <= 3'd0;
      l1a_q   <= '0;
      err_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wc_t_q  <= wc_t_d;
      crc_q   <= crc_d;
      ovf_q   <= ovf_d;
      late_q  <= late_d;
      idx_q   <= idx_d;
      l1a_q   <= l1a_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
    end
  end

  assign DOUT      = dout_q;
  assign DOUT_VLD  = vld_q;
  assign DOUT_LAST = last_q;
  assign TAIL_BUSY = (state_q == LATCH) || (state_q == SEND);
  assign TAIL_DONE = (state_q == DONE);
  assign WC_OVF    = ovf_q;

endmodule

// File: tb/tb_dmb_tail_gen.sv
// Directed, table-driven bench for dmb_tail_gen: one table row per event scenario,
// with hand-computed trailer words and an independent CRC-22 model for W6/W7.
module tb_dmb_tail_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLR_EVT = 1'b0;
  logic        DIN_VLD = 1'b0;
  logic [15:0] DIN = '0;
  logic        STRT_TAIL = 1'b0;
  logic [23:0] L1A_NUM = '0;
  logic [7:0]  ERR_FLAGS = '0;
  logic        DOUT_RDY = 1'b0;
  logic [15:0] DOUT;
  logic        DOUT_VLD, DOUT_LAST, TAIL_BUSY, TAIL_DONE, WC_OVF;

  always #5 CLK = ~CLK;

  dmb_tail_gen dut (
    .CLK       (CLK),
    .RST       (RST),
    .CLR_EVT   (CLR_EVT),
    .DIN_VLD   (DIN_VLD),
    .DIN       (DIN),
    .STRT_TAIL (STRT_TAIL),
    .L1A_NUM   (L1A_NUM),
    .ERR_FLAGS (ERR_FLAGS),
    .DOUT_RDY  (DOUT_RDY),
    .DOUT      (DOUT),
    .DOUT_VLD  (DOUT_VLD),
    .DOUT_LAST (DOUT_LAST),
    .TAIL_BUSY (TAIL_BUSY),
    .TAIL_DONE (TAIL_DONE),
    .WC_OVF    (WC_OVF)
  );

  // rdy: 0 = always high, 1 = toggle, 2 = random. din_at/strt_at: SEND-phase pulse iteration.
  typedef struct {
    int              nwords;
    logic [15:0]     base;
    logic [23:0]     l1a;
    logic [7:0]      err;
    int              rdy;
    bit              use_clr;
    bit              preload;
    int              din_at;
    int              strt_at;
    int              abort_n;
    logic [5:0][15:0] exp;
  } scn_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] cap [8];
  scn_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] model_crc(input logic [21:0] crc, input logic [15:0] d);
    logic [21:0] c = crc;
    for (int b = 15; b >= 0; b--) begin
      if (c[21] ^ d[b]) c = (c << 1) ^ 22'h3;
      else              c = c << 1;
    end
    return c;
  endfunction

  function automatic scn_t mk(input int n, input logic [15:0] base, input logic [23:0] l1a,
                              input logic [7:0] err, input int rdy, input bit clr,
                              input bit pre, input int din_at, input int strt_at,
                              input int abort_n, input logic [5:0][15:0] exp);
    scn_t s;
    s.nwords = n; s.base = base; s.l1a = l1a; s.err = err; s.rdy = rdy;
    s.use_clr = clr; s.preload = pre; s.din_at = din_at; s.strt_at = strt_at;
    s.abort_n = abort_n; s.exp = exp;
    return s;
  endfunction

  task automatic send_event(input scn_t s);
    L1A_NUM   = s.l1a;
    ERR_FLAGS = s.err;
    if (s.preload || s.nwords == 0) begin
      @(negedge CLK);
      CLR_EVT = 1'b1;
      @(negedge CLK);
      CLR_EVT = 1'b0;
    end
    if (s.preload) begin
      force dut.wcnt_q = 22'h3FFFFA;
      #1;
      release dut.wcnt_q;
    end
    for (int i = 0; i < s.nwords; i++) begin
      @(negedge CLK);
      DIN_VLD   = 1'b1;
      DIN       = s.base + 16'(i);
      CLR_EVT   = s.use_clr && (i == 0) && !s.preload;
      STRT_TAIL = (i == s.nwords - 1);
    end
    if (s.nwords == 0) begin
      @(negedge CLK);
      STRT_TAIL = 1'b1;
    end
  endtask

  task automatic collect(input int e, input scn_t s);
    int   xfers = 0;
    int   dones = 0;
    int   first_vld = -1;
    bit   prev_stall = 0;
    bit   finished = 0;
    logic [15:0] prev_d = '0;
    for (int it = 0; it < 200 && !finished; it++) begin
      @(negedge CLK);
      if (it == 0) begin
        chk($sformatf("e%0d busy in latch", e), TAIL_BUSY, 1);
        chk($sformatf("e%0d ovf before tail", e), WC_OVF, s.preload);
      end
      if (s.abort_n > 0 && xfers == s.abort_n) begin
        DOUT_RDY = 1'b0;
        RST = 1'b1;
        #1;
        chk($sformatf("e%0d abort outputs", e),
            {DOUT, DOUT_VLD, DOUT_LAST, TAIL_BUSY, TAIL_DONE, WC_OVF}, '0);
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          chk($sformatf("e%0d abort no done", e), TAIL_DONE, 0);
        end
        RST = 1'b0;
        return;
      end
      if (first_vld < 0 && DOUT_VLD) first_vld = it;
      if (TAIL_DONE) dones++;
      if (prev_stall) begin
        chk($sformatf("e%0d hold data", e), DOUT, prev_d);
        chk($sformatf("e%0d hold vld", e), DOUT_VLD, 1);
      end
      if (xfers == 8) begin
        chk($sformatf("e%0d done pulse", e), TAIL_DONE, 1);
        chk($sformatf("e%0d vld after w7", e), DOUT_VLD, 0);
        chk($sformatf("e%0d done count", e), dones, 1);
        DOUT_RDY = 1'b0;
        finished = 1;
      end else begin
        CLR_EVT   = 1'b0;
        STRT_TAIL = (it == s.strt_at);
        DIN_VLD   = (it == s.din_at);
        DIN       = 16'hDEAD;
        case (s.rdy)
          0:       DOUT_RDY = 1'b1;
          1:       DOUT_RDY = (it % 2) == 1;
          default: DOUT_RDY = 1'($urandom_range(0, 1));
        endcase
        if (DOUT_VLD && DOUT_RDY) begin
          cap[xfers] = DOUT;
          chk($sformatf("e%0d last w%0d", e, xfers), DOUT_LAST, (xfers == 7));
          xfers++;
        end
        prev_stall = DOUT_VLD && !DOUT_RDY;
        prev_d     = DOUT;
      end
    end
    STRT_TAIL = 1'b0;
    DIN_VLD   = 1'b0;
    if (!finished) begin
      chk($sformatf("e%0d timeout xfers", e), xfers, 8);
      return;
    end
    chk($sformatf("e%0d first vld latency", e), first_vld, 1);
    @(negedge CLK);
    chk($sformatf("e%0d done one cycle", e), TAIL_DONE, 0);
    chk($sformatf("e%0d ovf cleared", e), WC_OVF, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk($sformatf("e%0d idle after", e), {DOUT_VLD, TAIL_BUSY, TAIL_DONE}, 0);
    end
  endtask

  task automatic check_words(input int e, input scn_t s);
    logic [21:0] crc = '0;
    logic [15:0] w6, w7;
    for (int i = 0; i < s.nwords; i++) crc = model_crc(crc, s.base + 16'(i));
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("e%0d w%0d", e, k), cap[k], s.exp[k]);
      crc = model_crc(crc, s.exp[k]);
    end
    w6 = {4'hE, 1'b0, crc[10:0]};
    w7 = {4'hE, 1'b0, crc[21:11]};
    chk($sformatf("e%0d w6 crc", e), cap[6], w6);
    chk($sformatf("e%0d w7 crc", e), cap[7], w7);
  endtask

  initial begin
    // Expected words listed W5..W0 (packed array, index 0 is rightmost).
    tbl[0] = mk(10, 16'h0001, 24'h123456, 8'h00, 0, 1, 0, -1, -1, 0,
                {16'hE000, 16'hE012, 16'hF000, 16'hF000, 16'hF123, 16'hF456});
    tbl[1] = mk(3, 16'h1000, 24'hABCDEF, 8'h5A, 1, 1, 0, -1, -1, 0,
                {16'hE000, 16'hE00B, 16'hF000, 16'hF05A, 16'hFABC, 16'hFDEF});
    tbl[2] = mk(10, 16'h2000, 24'h000001, 8'h00, 0, 1, 1, -1, -1, 0,
                {16'hE3FF, 16'hEFFF, 16'hF100, 16'hF000, 16'hF000, 16'hF001});
    tbl[3] = mk(4, 16'h4000, 24'h000002, 8'h01, 0, 1, 0, 2, -1, 0,
                {16'hE000, 16'hE00C, 16'hF000, 16'hF081, 16'hF000, 16'hF002});
    tbl[4] = mk(5, 16'h5000, 24'h000003, 8'h00, 0, 1, 0, -1, -1, 4,
                {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0});
    tbl[5] = mk(2, 16'h0300, 24'h000004, 8'h00, 2, 0, 0, -1, -1, 0,
                {16'hE000, 16'hE00A, 16'hF000, 16'hF000, 16'hF000, 16'hF004});
    tbl[6] = mk(1, 16'h7777, 24'h00ABCD, 8'h80, 0, 1, 0, -1, 3, 0,
                {16'hE000, 16'hE009, 16'hF000, 16'hF080, 16'hF00A, 16'hFBCD});
    tbl[7] = mk(0, 16'h0000, 24'hFFFFFF, 8'hFF, 1, 1, 0, -1, -1, 0,
                {16'hE000, 16'hE008, 16'hF000, 16'hF0FF, 16'hFFFF, 16'hFFFF});

    repeat (2) @(negedge CLK);
    chk("reset outputs", {DOUT, DOUT_VLD, DOUT_LAST, TAIL_BUSY, TAIL_DONE, WC_OVF}, '0);
    RST = 1'b0;
    @(negedge CLK);

    for (int e = 0; e < 8; e++) begin
      send_event(tbl[e]);
      collect(e, tbl[e]);
      if (tbl[e].abort_n == 0) check_words(e, tbl[e]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
